serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial two's-complement adder, the additive counterpart of the parallel `Subtractor` in the Baby datapath. It accepts two `nrOfBits` operands and a carry-in under a start/done handshake. It adds them LSB-first, one bit per clock, in the serial style of the original Manchester Baby arithmetic, then presents a held sum with carry-out and signed-overflow flags. It sits beside the accumulator path as an area-light alternative to the parallel arithmetic unit.

## Interface
- `nrOfBits`, 32, operand/result width (≥2)
- `clk`  input  1  sole clock; all state updates on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `start`  input  1  request; sampled only in IDLE
- `carryIn`  input  1  carry into bit 0, captured with operands
- `dataA`  input  nrOfBits  operand A, captured on accepted start
- `dataB`  input  nrOfBits  operand B, captured on accepted start
- `busy`  output  1  high while in RUN
- `done`  output  1  single-cycle pulse: result/flags just updated
- `result`  output  nrOfBits  A + B + carryIn mod 2^nrOfBits, held
- `carryOut`  output  1  carry out of MSB, held
- `overflow`  output  1  signed overflow (carry into MSB XOR carry out), held

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE after the nrOfBits-th bit.
  - DONE → IDLE unconditionally.
- On accepted start:
  - latch dataA and dataB into shift registers sA and sB.
  - latch carryIn into the carry flop c.
  - clear the sum shift register and the bit counter.
- Each RUN cycle:
  - s = sA[0] ^ sB[0] ^ c
  - c ← majority(sA[0], sB[0], c)
  - shift s into the MSB of the sum register; shift sA and sB right
  - counter++
- On the final bit:
  - capture the carry into the MSB (the c value before update) for the overflow calculation.
- On entering DONE:
  - copy the sum register to `result`.
  - update `carryOut` to the final c and `overflow` to the computed flag.
  - `done`=1 for that cycle only.
- Outputs `result`/`carryOut`/`overflow` change only on entry to DONE; they are stable otherwise.
- Counter width is clog2(nrOfBits)+1; no wrap occurs within an operation.
- `start` in RUN or DONE is ignored (not queued).
- Input changes after acceptance have no effect on the operation in flight.

## Timing
- Start sampled at edge k. RUN occupies edges k+1 … k+nrOfBits; one bit is processed per edge.
- `busy`=1 from after edge k until edge k+nrOfBits.
- `done`=1 and new result visible from after edge k+nrOfBits until edge k+nrOfBits+1.
- Latency start→done: nrOfBits+1 cycles. Throughput: one operation per nrOfBits+2 cycles.
- `start` held high continuously is accepted at the first IDLE edge after DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `carryOut`=0, `overflow`=0, counter=0.
- `rst` has priority over `start` and all state updates.
- `rst` mid-RUN aborts the operation: no `done`, and outputs return to reset values on the next edge.

## Test plan
- Reset check: assert `rst` 2 cycles, then sample → all outputs 0, `busy`=0.
- Basic sum: A=5, B=3, cin=0 → after 33 cycles `done` pulses once; `result`=8, `carryOut`=0, `overflow`=0. `busy` is high for exactly 32 cycles.
- Unsigned carry: A=0xFFFFFFFF, B=1, cin=0 → `result`=0, `carryOut`=1, `overflow`=0.
- Signed overflow and carry-in:
  - A=0x7FFFFFFF, B=0, cin=1 → `result`=0x80000000, `carryOut`=0, `overflow`=1.
  - A=0x80000000, B=0x80000000, cin=0 → `result`=0, `carryOut`=1, `overflow`=1.
- Handshake robustness:
  - Pulse `start` with A=1, B=1, then pulse `start` again mid-RUN with A=100 → `result`=2, exactly one `done`.
  - Hold `start` high → the next operation begins the cycle after `done`.
- Reset mid-operation: start A=10, B=20; assert `rst` at RUN bit 15 → no `done`, `result`=0, `busy`=0. A fresh start with A=10, B=20 then yields 30.

Source files
------------

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int nrOfBits = 32
);
  logic                start;
  logic                carryIn;
  logic [nrOfBits-1:0] dataA;
  logic [nrOfBits-1:0] dataB;
  logic                busy;
  logic                done;
  logic [nrOfBits-1:0] result;
  logic                carryOut;
  logic                overflow;

  modport master (
    output start, carryIn, dataA, dataB,
    input  busy, done, result, carryOut, overflow
  );

  modport slave (
    input  start, carryIn, dataA, dataB,
    output busy, done, result, carryOut, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: LSB-first, one bit per clock, held sum
// with carry-out and signed-overflow flags under a start/done handshake.
module serial_adder #(
  parameter int nrOfBits = 32
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = $clog2(nrOfBits) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(nrOfBits - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [nrOfBits-1:0] sa, sb;
  logic [nrOfBits-2:0] ssum;
  logic [nrOfBits-1:0] sum_cat;
  logic                c;
  logic                accept, last_bit;
  logic                s_bit, c_nxt;
  logic [nrOfBits-1:0] res_q;
  logic                cout_q, ovf_q;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_bit   = sa[0] ^ sb[0] ^ c;
  assign c_nxt   = majority(sa[0], sb[0], c);
  // Sum register holds the nrOfBits-1 bits already produced; the final bit
  // joins at the MSB so the complete sum is available on the last RUN edge.
  assign sum_cat = {s_bit, ssum};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= '0;
      else if (state == RUN)
        cnt <= cnt + 1'b1;
      // c here is the carry into the MSB; c_nxt is the carry out of it.
      if (last_bit) begin
        res_q  <= sum_cat;
        cout_q <= c_nxt;
        ovf_q  <= c ^ c_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sa   <= bus.dataA;
      sb   <= bus.dataB;
      c    <= bus.carryIn;
      ssum <= '0;
    end else if (state == RUN) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      c    <= c_nxt;
      ssum <= sum_cat[nrOfBits-1:1];
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.result   = res_q;
  assign bus.carryOut = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: handshake timing, sums, carry and overflow flags.
module tb_serial_adder;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  serial_adder_if #(.nrOfBits(W)) bus ();

  serial_adder #(.nrOfBits(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] res;
  logic         co, ov;
  int           busy_n, done_n, done_at, rebusy_at;

  // Issues one operation and observes 40 post-acceptance cycles.
  // hold: keep start high; mid_j: re-pulse start with A=100 at that cycle;
  // rst_j: assert rst for one edge at that cycle (-1 disables).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit hold, input int mid_j, input int rst_j);
    busy_n = 0; done_n = 0; done_at = -1; rebusy_at = -1;
    res = '0; co = 1'b0; ov = 1'b0;
    bus.dataA   = a;
    bus.dataB   = b;
    bus.carryIn = cin;
    bus.start   = 1'b1;
    step();
    for (int j = 0; j < 40; j++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = j;
          res = bus.result;
          co  = bus.carryOut;
          ov  = bus.overflow;
        end
      end
      if (done_at >= 0 && j > done_at && bus.busy && rebusy_at < 0) rebusy_at = j;
      bus.start = hold || (j == mid_j);
      if (j == mid_j) bus.dataA = 32'd100;
      if (!hold && j == 0) begin
        bus.dataA   = ~a;
        bus.carryIn = ~cin;
      end
      rst = (j == rst_j);
      step();
    end
    bus.start = 1'b0;
    rst = 1'b0;
    for (int j = 0; j < 40; j++) step();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.carryIn = 1'b0;
    bus.dataA   = '0;
    bus.dataB   = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cout", 64'(bus.carryOut), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);

    run_op(32'd5, 32'd3, 1'b0, 1'b0, -1, -1);
    chk("basic_result", 64'(res), 64'd8);
    chk("basic_cout", 64'(co), 64'd0);
    chk("basic_ovf", 64'(ov), 64'd0);
    chk("basic_done_cnt", 64'(done_n), 64'd1);
    chk("basic_busy_cnt", 64'(busy_n), 64'd32);
    chk("basic_latency", 64'(done_at), 64'd32);
    chk("basic_held", 64'(bus.result), 64'd8);

    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, -1, -1);
    chk("ucarry_result", 64'(res), 64'd0);
    chk("ucarry_cout", 64'(co), 64'd1);
    chk("ucarry_ovf", 64'(ov), 64'd0);

    run_op(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, -1, -1);
    chk("posovf_result", 64'(res), 64'h8000_0000);
    chk("posovf_cout", 64'(co), 64'd0);
    chk("posovf_ovf", 64'(ov), 64'd1);

    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, -1, -1);
    chk("negovf_result", 64'(res), 64'd0);
    chk("negovf_cout", 64'(co), 64'd1);
    chk("negovf_ovf", 64'(ov), 64'd1);

    run_op(32'd1, 32'd1, 1'b0, 1'b0, 10, -1);
    chk("midstart_result", 64'(res), 64'd2);
    chk("midstart_done_cnt", 64'(done_n), 64'd1);

    run_op(32'd7, 32'd9, 1'b1, 1'b1, -1, -1);
    chk("hold_result", 64'(res), 64'd17);
    chk("hold_latency", 64'(done_at), 64'd32);
    chk("hold_restart", 64'(rebusy_at), 64'd34);

    run_op(32'd10, 32'd20, 1'b0, 1'b0, -1, 15);
    chk("abort_done_cnt", 64'(done_n), 64'd0);
    chk("abort_busy_cnt", 64'(busy_n), 64'd16);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_cout", 64'(bus.carryOut), 64'd0);

    run_op(32'd10, 32'd20, 1'b0, 1'b0, -1, -1);
    chk("fresh_result", 64'(res), 64'd30);
    chk("fresh_done_cnt", 64'(done_n), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
